// File: rtl/l2_msg2_noc_serializer_if.sv
// L2 msg2 input channel plus the outgoing NoC flit channel.
// The serializer is the slave on msg2 and drives the NoC side.
interface l2_msg2_noc_serializer_if;
  logic        msg2_valid;
  logic        msg2_ready;
  logic [7:0]  msg2_type;
  logic [25:0] msg2_tag;
  logic [5:0]  msg2_dest;
  logic        msg2_has_data;
  logic [63:0] msg2_data;
  logic        noc_valid;
  logic        noc_ready;
  logic [63:0] noc_flit;

  modport master (
    output msg2_valid, msg2_type, msg2_tag, msg2_dest, msg2_has_data, msg2_data,
    input  msg2_ready,
    input  noc_valid, noc_flit,
    output noc_ready
  );

  modport slave (
    input  msg2_valid, msg2_type, msg2_tag, msg2_dest, msg2_has_data, msg2_data,
    output msg2_ready,
    output noc_valid, noc_flit,
    input  noc_ready
  );
endinterface

// File: rtl/l2_msg2_noc_serializer.sv
// Queues L2 msg2 messages in a small FIFO and emits each as header/address/
// optional data 64-bit flits on a valid/ready NoC channel.
module l2_msg2_noc_serializer #(
  parameter int DEPTH = 4,
  parameter int MY_ID = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  l2_msg2_noc_serializer_if.slave bus,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);
  localparam logic [5:0]  SRC_ID   = 6'(MY_ID);

  typedef struct packed {
    logic [7:0]  msg_type;
    logic [25:0] tag;
    logic [5:0]  dest;
    logic        has_data;
    logic [63:0] data;
  } entry_t;

  typedef enum logic [1:0] {IDLE, HDR, ADDR, DATA} state_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  state_t        state;
  logic          full, enq, pop, more;
  logic [63:0]   flit;

  assign head           = mem[rd_ptr];
  assign full           = (fifo_count == FULL_CNT);
  assign bus.msg2_ready = !full;
  assign enq            = bus.msg2_valid && !full;
  // Entry leaves the queue only when its final flit is accepted.
  assign pop            = bus.noc_ready &&
                          ((state == ADDR && !head.has_data) || state == DATA);
  // Something is still queued after this pop (including a same-cycle enqueue).
  assign more           = (fifo_count > ONE_CNT) || enq;

  always_ff @(posedge clk) begin
    if (enq)
      mem[wr_ptr] <= {bus.msg2_type, bus.msg2_tag, bus.msg2_dest,
                      bus.msg2_has_data, bus.msg2_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      state      <= IDLE;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
      case (state)
        IDLE: if (fifo_count != '0) state <= HDR;
        HDR:  if (bus.noc_ready) state <= ADDR;
        ADDR: if (bus.noc_ready)
                state <= head.has_data ? DATA : (more ? HDR : IDLE);
        DATA: if (bus.noc_ready) state <= more ? HDR : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Flit is decoded from the held state and head entry, so it is stable under stall.
  always_comb begin
    flit = '0;
    case (state)
      HDR:     flit = {head.dest, head.msg_type, (head.has_data ? 2'd2 : 2'd1),
                       SRC_ID, 42'd0};
      ADDR:    flit = {38'd0, head.tag};
      DATA:    flit = head.data;
      default: flit = '0;
    endcase
  end

  assign bus.noc_flit  = flit;
  assign bus.noc_valid = (state != IDLE);
  assign busy          = (fifo_count != '0) || (state != IDLE);
endmodule

// File: tb/tb_l2_msg2_noc_serializer.sv
// Scoreboard bench: issued messages push expected flits; a negedge monitor
// pops and compares every accepted flit and checks stall stability.
module tb_l2_msg2_noc_serializer;
  localparam int DEPTH = 4;
  localparam int MY_ID = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] fifo_count;
  logic       busy;
  logic       rdy_rand = 1'b0;
  logic       rdy_force = 1'b0;
  logic       rnd_rdy = 1'b0;

  int tests = 0;
  int fails = 0;

  logic [63:0] exp_q[$];
  logic [63:0] acc_log[$];
  int          acc_at_enq;
  logic        send_done;
  logic        stalled = 1'b0;
  logic [63:0] held_flit;

  l2_msg2_noc_serializer_if bus();

  l2_msg2_noc_serializer #(.DEPTH(DEPTH), .MY_ID(MY_ID)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .fifo_count(fifo_count), .busy(busy)
  );

  always #5 clk = ~clk;

  assign bus.noc_ready = rdy_rand ? rnd_rdy : rdy_force;
  always @(posedge clk) begin
    #1 rnd_rdy = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] hdr_of(input logic [7:0] t, input logic [5:0] d,
                                         input logic h);
    logic [63:0] v;
    v = 64'(d) << 58;
    v = v | (64'(t) << 50);
    v = v | ((h ? 64'd2 : 64'd1) << 48);
    v = v | (64'(MY_ID) << 42);
    return v;
  endfunction

  // Reference model: a message is simply its list of flits.
  function automatic void push_msg(input logic [7:0] t, input logic [25:0] a,
                                   input logic [5:0] d, input logic h,
                                   input logic [63:0] x);
    exp_q.push_back(hdr_of(t, d, h));
    exp_q.push_back(64'(a));
    if (h) exp_q.push_back(x);
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] t, input logic [25:0] a, input logic [5:0] d,
                      input logic h, input logic [63:0] x);
    bus.msg2_type     = t;
    bus.msg2_tag      = a;
    bus.msg2_dest     = d;
    bus.msg2_has_data = h;
    bus.msg2_data     = x;
    bus.msg2_valid    = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.msg2_ready) begin
        push_msg(t, a, d, h, x);
        acc_at_enq = acc_log.size();
        @(posedge clk);
        #1;
        bus.msg2_valid = 1'b0;
        bus.msg2_type  = 8'($urandom);
        bus.msg2_tag   = 26'($urandom);
        bus.msg2_dest  = 6'($urandom);
        bus.msg2_data  = {$urandom, $urandom};
        return;
      end
    end
    tests++; fails++;
    $display("FAIL send_timeout: message never accepted");
    bus.msg2_valid = 1'b0;
  endtask

  task automatic send_rand();
    send(8'($urandom), 26'($urandom), 6'($urandom), 1'($urandom_range(0, 1)),
         {$urandom, $urandom});
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) break;
    end
    chk({nm, "_pending"}, 64'(exp_q.size()), 64'd0);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    chk({nm, "_valid"}, 64'(bus.noc_valid), 64'd0);
    chk({nm, "_count"}, 64'(fifo_count), 64'd0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        if (!bus.noc_valid) chk("stall_valid_hold", 64'(bus.noc_valid), 64'd1);
        else                chk("stall_flit_hold", bus.noc_flit, held_flit);
      end
      stalled = 1'b0;
      if (bus.noc_valid) begin
        if (bus.noc_ready) begin
          acc_log.push_back(bus.noc_flit);
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_flit: got %h with nothing expected", bus.noc_flit);
          end else begin
            chk("flit_order", bus.noc_flit, exp_q.pop_front());
          end
        end else begin
          stalled   = 1'b1;
          held_flit = bus.noc_flit;
        end
      end
    end
  end

  initial begin
    bus.msg2_valid = 1'b0;
    bus.msg2_type = '0; bus.msg2_tag = '0; bus.msg2_dest = '0;
    bus.msg2_has_data = 1'b0; bus.msg2_data = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.msg2_ready), 64'd1);
    chk("rst_valid", 64'(bus.noc_valid), 64'd0);
    chk("rst_flit", bus.noc_flit, 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single no-data message
    rdy_force = 1'b1;
    acc_log = {};
    send(8'h12, 26'h155AAAA, 6'd5, 1'b0, 64'h0);
    wait_idle("single");
    chk("single_nflits", 64'(acc_log.size()), 64'd2);
    if (acc_log.size() >= 2) begin
      chk("single_hdr", acc_log[0], 64'h1449_0000_0000_0000);
      chk("single_addr", acc_log[1], 64'h0000_0000_0155_AAAA);
    end

    // Data message with a 5-cycle stall on the address flit
    rdy_force = 1'b0;
    acc_log = {};
    send(8'h3C, 26'h2ABCDEF, 6'd17, 1'b1, 64'hDEADBEEF_CAFEF00D);
    for (int i = 0; i < 20 && !bus.noc_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("data_hdr_shown", 64'(bus.noc_valid), 64'd1);
    rdy_force = 1'b1;
    @(posedge clk); #1;
    rdy_force = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("addr_hold", bus.noc_flit, 64'h0000_0000_02AB_CDEF);
    end
    @(posedge clk); #1;
    rdy_force = 1'b1;
    wait_idle("data");
    chk("data_nflits", 64'(acc_log.size()), 64'd3);
    if (acc_log.size() >= 3) begin
      chk("data_cnt_field", 64'(acc_log[0][49:48]), 64'd2);
      chk("data_payload", acc_log[2], 64'hDEADBEEF_CAFEF00D);
    end

    // Fill: 4 accepted, 5th stalls until the first pop
    rdy_force = 1'b0;
    acc_log = {};
    send(8'h01, 26'h0000111, 6'd1, 1'b0, 64'h0);
    repeat (3) send_rand();
    chk("fill_count", 64'(fifo_count), 64'd4);
    chk("fill_ready", 64'(bus.msg2_ready), 64'd0);
    send_done = 1'b0;
    fork
      begin
        send_rand();
        send_done = 1'b1;
      end
    join_none
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("fill_5th_stalled", 64'(bus.msg2_ready), 64'd0);
    chk("fill_5th_count", 64'(fifo_count), 64'd4);
    rdy_force = 1'b1;
    for (int i = 0; i < 100 && !send_done; i++) begin
      @(posedge clk); #1;
    end
    chk("fill_5th_done", 64'(send_done), 64'd1);
    chk("fill_5th_after_pop", 64'(acc_at_enq >= 2), 64'd1);
    wait_idle("fill");

    // Wrap-around stream with random back-pressure
    rdy_rand = 1'b1;
    for (int m = 0; m < 10; m++) begin
      send_rand();
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    wait_idle("stream");
    rdy_rand = 1'b0;

    // Reset during the DATA flit with 3 entries queued
    rdy_force = 1'b0;
    send(8'hA5, 26'h0001234, 6'd9, 1'b1, 64'h0123_4567_89AB_CDEF);
    send_rand();
    send_rand();
    rdy_force = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rdy_force = 1'b0;
    chk("pre_rst_data", bus.noc_flit, 64'h0123_4567_89AB_CDEF);
    chk("pre_rst_count", 64'(fifo_count), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(bus.noc_valid), 64'd0);
    chk("midrst_count", 64'(fifo_count), 64'd0);
    chk("midrst_ready", 64'(bus.msg2_ready), 64'd1);
    exp_q = {};
    acc_log = {};
    @(posedge clk); #1;
    rst_n = 1'b1;
    rdy_force = 1'b1;
    send(8'h77, 26'h3FFFFFF, 6'd63, 1'b0, 64'h0);
    wait_idle("post_rst");
    if (acc_log.size() >= 1) chk("post_rst_hdr", acc_log[0], hdr_of(8'h77, 6'd63, 1'b0));
    else chk("post_rst_nflits", 64'(acc_log.size()), 64'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/l2_msg2_noc_serializer.md
Name: l2_msg2_noc_serializer

Overview:
- Downstream consumer of the L2 msg2 output channel (type/tag/dest/data with valid/ready).
- Buffers outgoing L2 messages in a small FIFO so that msg2 back-pressure (msg2_valid=1, msg2_ready=0) only occurs when the queue is full.
- Serializes each message into 64-bit NoC flits (header, address, optional data) on a valid/ready NoC channel.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- MY_ID, 0, 6-bit L2 tile id placed in the header src field.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- msg2_valid  in  1  L2 presents a message
- msg2_ready  out  1  queue can accept; equals !full
- msg2_type  in  8  message type
- msg2_tag  in  26  line tag/address
- msg2_dest  in  6  destination tile id
- msg2_has_data  in  1  message carries a data flit
- msg2_data  in  64  line data; ignored when has_data=0
- noc_valid  out  1  flit valid
- noc_ready  in  1  NoC accepts flit
- noc_flit  out  64  flit payload
- fifo_count  out  clog2(DEPTH)+1  occupied entries
- busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset: one clock; asynchronous active-low reset rst_n.
  - Effects: FIFO empty, pointers 0, FSM=IDLE.
  - Output values: msg2_ready=1 (combinational from !full), noc_valid=0, noc_flit=0, fifo_count=0, busy=0.
  - Assertion mid-operation drops all queued and in-flight messages immediately; no partial flit is completed.
- Enqueue: occurs when msg2_valid && msg2_ready at posedge. The entry {type, tag, dest, has_data, data} is written at wr_ptr and wr_ptr is incremented mod DEPTH.
- Full: msg2_ready=0 when fifo_count==DEPTH. There is no enqueue-on-pop bypass: a full FIFO refuses input even in a cycle where a pop occurs.
- Pop: the head entry is popped on acceptance of its last flit. rd_ptr is incremented mod DEPTH.
- fifo_count: +1 on enqueue, −1 on pop, unchanged when both or neither occur.
- FSM states: IDLE, HDR, ADDR, DATA.
  - IDLE: if FIFO non-empty, go to HDR next cycle.
  - HDR: on handshake go to ADDR.
  - ADDR: on handshake, go to DATA if has_data, else pop. Then go to HDR if another entry remains after the pop, else IDLE.
  - DATA: on handshake pop, then go to HDR or IDLE by the same rule as ADDR.
- Latency: a message enqueued at edge N has its header flit valid in the cycle after edge N+1 (IDLE→HDR). Back-to-back messages have no idle cycle between them (last flit → HDR).
- Flit formats:
  - Header: [63:58]=dest, [57:50]=type, [49:48]=payload flit count (1 without data, 2 with data), [47:42]=MY_ID, [41:0]=0.
  - Address: [63:26]=0, [25:0]=tag.
  - Data: msg2_data as captured.
- noc_valid=1 in HDR/ADDR/DATA, 0 in IDLE.
- While noc_valid && !noc_ready, noc_flit and the FSM state must hold stable; no flit is skipped or repeated.
- Data is captured at enqueue. Later changes on the msg2 inputs do not affect queued entries.
- Pointer wrap: with DEPTH=4, pointers wrap 3→0. Ordering is strict FIFO.
- busy = (fifo_count!=0) || (state!=IDLE).

Test Plan:
- Single no-data message: type=0x12, tag=0x155AAAA, dest=5, noc_ready=1.
  - Required response: flits 0x1449_0000_0000_0000 (header with MY_ID=0), then 0x0000_0000_0155_AAAA.
  - Afterwards: noc_valid=0, busy=0, fifo_count=0.
- Data message: has_data=1, data=0xDEADBEEF_CAFEF00D. Header [49:48]=2; three flits in order. Hold noc_ready=0 for 5 cycles during ADDR → flit value stable, no advance.
- Fill: noc_ready=0, present 5 messages back-to-back → 4 accepted, msg2_ready=0 after the 4th, fifo_count=4.
  - With msg2_valid held at 1 and msg2_ready=0, the 5th message stays stalled.
  - Raise noc_ready → the 5th message is accepted only after the first pop; messages emerge in order.
- Wrap-around: stream 10 mixed messages with random noc_ready → all flits match a reference queue model, pointers wrap, no loss or duplication.
- Reset mid-operation: assert rst_n=0 during the DATA flit with 3 entries queued → noc_valid=0, fifo_count=0, msg2_ready=1 immediately. After release, a new message produces a correct header.
